// File: rtl/ram16_access_arbiter_pkg.sv
// Shared definitions for the two-requester RAM access arbiter:
// FSM state encoding, requester ids and the wide-access factor.
package ram16_access_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACC0 = 3'd1,
        ST_ACC1 = 3'd2,
        ST_CAP  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    localparam int   NUM_REQ = 2;
    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    // Requester 1 is treated as the previous winner, so requester 0 wins the first tie.
    localparam logic RESET_LAST_GRANT = REQ_ID1;

    // A requester-side word is this many RAM halfwords.
    localparam int WIDE_FACTOR = 2;

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram16_access_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: grants the single requester, or on a tie the one
// that did not win last time. Grants only while enabled.
module rr_arbiter2
    import ram16_access_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_id
);

    logic last_grant;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        gnt_id = REQ_ID0;
        gnt    = '0;
        if (en) begin
            case (req)
                2'b01:   gnt_id = REQ_ID0;
                2'b10:   gnt_id = REQ_ID1;
                2'b11:   gnt_id = ~last_grant;
                default: gnt_id = REQ_ID0;
            endcase
            if (|req) begin
                gnt = id_to_onehot(gnt_id);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= RESET_LAST_GRANT;
        end else if (|gnt) begin
            last_grant <= gnt_id;
        end
    end

endmodule

// File: rtl/ram16_access_arbiter.sv
// Shares a 16-bit block RAM between two requesters; serialises each request into
// one or two RAM cycles and assembles/splits 32-bit words in either endian order.
module ram16_access_arbiter
    import ram16_access_arbiter_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ-1:0]               req_wide,
    input  logic [NUM_REQ*ADDR_W-1:0]        req_addr,
    input  logic [NUM_REQ*WIDE_FACTOR*DATA_W-1:0] req_wdata,
    input  logic                             big_endian,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             rsp_valid,
    output logic                             rsp_id,
    output logic [WIDE_FACTOR*DATA_W-1:0]    rsp_rdata,
    output logic [ADDR_W-1:0]                ram_addr,
    output logic                             ram_we,
    output logic [DATA_W-1:0]                ram_wdata,
    input  logic [DATA_W-1:0]                ram_rdata
);

    localparam int WORD_W = WIDE_FACTOR * DATA_W;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant;
    logic                grant_id;
    logic                grant_any;
    logic                arb_en;
    logic [ADDR_W-1:0]   grant_addr;

    logic                write_q;
    logic                wide_q;
    logic                be_q;
    logic                id_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   first_rd_q;

    logic [ADDR_W-1:0]   ram_addr_q;
    logic [WORD_W-1:0]   rsp_rdata_q;

    logic [DATA_W-1:0]   wr_hi, wr_lo;
    logic [DATA_W-1:0]   first_half, second_half;
    logic [WORD_W-1:0]   rd_word;

    // Reset gates the enable so no grant pulse escapes while rst is high.
    assign arb_en = (state_q == ST_IDLE) && !rst;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (arb_en),
        .req    (req_valid),
        .gnt    (grant),
        .gnt_id (grant_id)
    );

    assign grant_any  = |grant;
    assign grant_addr = req_addr[grant_id*ADDR_W +: ADDR_W];
    assign req_ready  = grant;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_any) state_d = ST_ACC0;
            ST_ACC0: state_d = wide_q ? ST_ACC1 : ST_CAP;
            ST_ACC1: state_d = ST_CAP;
            ST_CAP:  state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Big endian puts the upper half at the lower address; narrow writes use the low half.
    assign wr_hi       = wdata_q[WORD_W-1 -: DATA_W];
    assign wr_lo       = wdata_q[DATA_W-1:0];
    assign first_half  = (wide_q && be_q) ? wr_hi : wr_lo;
    assign second_half = be_q ? wr_lo : wr_hi;

    always_comb begin
        ram_wdata = '0;
        case (state_q)
            ST_ACC0: ram_wdata = first_half;
            ST_ACC1: ram_wdata = second_half;
            default: ram_wdata = '0;
        endcase
    end

    assign ram_we   = write_q && ((state_q == ST_ACC0) || (state_q == ST_ACC1));
    assign ram_addr = ram_addr_q;

    always_comb begin
        rd_word = '0;
        if (!write_q) begin
            if (!wide_q) begin
                rd_word = {{DATA_W{1'b0}}, ram_rdata};
            end else if (be_q) begin
                rd_word = {first_rd_q, ram_rdata};
            end else begin
                rd_word = {ram_rdata, first_rd_q};
            end
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = rsp_valid & id_q;
    assign rsp_rdata = rsp_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ram_addr_q  <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant_any) begin
                ram_addr_q <= grant_addr;
            end else if ((state_q == ST_ACC0) && wide_q) begin
                ram_addr_q <= addr_q + ADDR_W'(1);
            end
            if (state_q == ST_CAP) begin
                rsp_rdata_q <= rd_word;
            end
        end
    end

    // NOTE: payload registers carry no reset; they are always loaded at grant before any use.
    always_ff @(posedge clk) begin
        if (grant_any) begin
            write_q <= req_write[grant_id];
            wide_q  <= req_wide[grant_id];
            addr_q  <= grant_addr;
            wdata_q <= req_wdata[grant_id*WORD_W +: WORD_W];
            be_q    <= big_endian;
            id_q    <= grant_id;
        end
        if (state_q == ST_ACC1) begin
            first_rd_q <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_ram16_access_arbiter.sv
// Self-checking bench: transaction-level schedule model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ram16_access_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_write = '0;
    logic [1:0]  req_wide = '0;
    logic [7:0]  req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        big_endian = 1'b0;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_rdata;
    logic [3:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = '0;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    logic [15:0] mem [16];
    logic [15:0] mm  [16];

    ram16_access_arbiter #(.ADDR_W(4), .DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_wide   (req_wide),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .big_endian (big_endian),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_rdata  (rsp_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM with a one-cycle registered read port
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: at each grant, schedule the access cycles and the response.
    logic        m_last;
    int          m_free_at, m_acc0, m_rsp_cyc;
    bit          m_wide, m_wr;
    logic        m_id;
    logic [3:0]  m_a, m_held_addr;
    logic [15:0] m_wd0, m_wd1;
    logic [31:0] m_rdata, m_held_rdata;
    logic [1:0]  e_rdy;
    logic        e_g;
    logic [31:0] e_wd;
    bit          e_we, e_big;
    logic [15:0] e_wdh;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_ram_we",    ram_we,    0);
            check("rst_ram_addr",  ram_addr,  0);
            check("rst_rsp_rdata", rsp_rdata, 0);
            m_last = 1'b1; m_free_at = 0; m_acc0 = -100; m_rsp_cyc = -100;
            m_held_rdata = '0; m_held_addr = '0; m_wide = 0;
        end else begin
            e_we = 0; e_wdh = '0;
            if (cyc == m_acc0) begin
                m_held_addr = m_a; e_we = m_wr; e_wdh = m_wd0;
            end else if (m_wide && cyc == m_acc0 + 1) begin
                m_held_addr = m_a + 4'd1; e_we = m_wr; e_wdh = m_wd1;
            end
            check("ram_addr", ram_addr, m_held_addr);
            check("ram_we", ram_we, e_we);
            if (e_we) check("ram_wdata", ram_wdata, e_wdh);
            if (cyc == m_rsp_cyc) begin
                m_held_rdata = m_rdata;
                check("rsp_id", rsp_id, m_id);
            end
            check("rsp_valid", rsp_valid, cyc == m_rsp_cyc);
            check("rsp_rdata", rsp_rdata, m_held_rdata);

            e_rdy = '0;
            if (cyc >= m_free_at && req_valid != 2'b00) begin
                e_g = (req_valid == 2'b11) ? ~m_last : req_valid[1];
                e_rdy[e_g] = 1'b1;
            end
            check("req_ready", req_ready, e_rdy);
            if (e_rdy != 2'b00) begin
                m_last = e_g; m_id = e_g;
                m_wr = req_write[e_g]; m_wide = req_wide[e_g];
                m_a = req_addr[e_g*4 +: 4];
                e_wd = req_wdata[e_g*32 +: 32];
                e_big = big_endian;
                m_acc0 = cyc + 1;
                m_rsp_cyc = cyc + (m_wide ? 4 : 3);
                m_free_at = cyc + (m_wide ? 5 : 4);
                if (!m_wide) begin
                    m_wd0 = e_wd[15:0];
                    m_wd1 = '0;
                end else if (e_big) begin
                    m_wd0 = e_wd[31:16]; m_wd1 = e_wd[15:0];
                end else begin
                    m_wd0 = e_wd[15:0];  m_wd1 = e_wd[31:16];
                end
                if (m_wr) begin
                    m_rdata = '0;
                    mm[m_a] = m_wd0;
                    if (m_wide) mm[m_a + 4'd1] = m_wd1;
                end else if (!m_wide) begin
                    m_rdata = {16'h0, mm[m_a]};
                end else if (e_big) begin
                    m_rdata = {mm[m_a], mm[m_a + 4'd1]};
                end else begin
                    m_rdata = {mm[m_a + 4'd1], mm[m_a]};
                end
            end
        end
    end

    task automatic run_req(input int id, input bit wr, input bit wide, input logic [3:0] a,
                           input logic [31:0] wd, input bit be, output logic [31:0] rdata,
                           output int lat, output int we_cnt, output logic [3:0] addr2);
        int t;
        bit got;
        rdata = '0; lat = -1; we_cnt = 0; addr2 = '0;
        req_write[id] = wr; req_wide[id] = wide; req_addr[id*4 +: 4] = a;
        req_wdata[id*32 +: 32] = wd; big_endian = be; req_valid[id] = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1;
        end
        if (!got) begin
            check("grant_timeout", 0, 1);
            req_valid[id] = 1'b0;
            return;
        end
        t = cyc;
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        req_wdata[id*32 +: 32] = ~wd; req_addr[id*4 +: 4] = ~a; big_endian = ~be;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (ram_we) we_cnt++;
            if (cyc == t + 2) addr2 = ram_addr;
            if (rsp_valid) begin
                got = 1; rdata = rsp_rdata; lat = cyc - t;
            end
        end
        if (!got) check("rsp_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          lat, wec;
        logic [3:0]  a2;
        bit          got, saw;
        logic        g;

        for (int i = 0; i < 16; i++) begin
            mem[i] = 16'h1000 + 16'(i);
        end
        mem[2] = 16'h0405; mem[3] = 16'h0607; mem[15] = 16'hABCD; mem[0] = 16'h1111;
        for (int i = 0; i < 16; i++) mm[i] = mem[i];

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // 1: narrow write then narrow read of the same halfword
        run_req(0, 1, 0, 4'd1, 32'h0000_4141, 1, rd, lat, wec, a2);
        check("t1_we_cycles", wec, 1);
        check("t1_mem1", mem[1], 16'h4141);
        check("t1_wr_latency", lat, 3);
        run_req(0, 0, 0, 4'd1, 32'h0, 1, rd, lat, wec, a2);
        check("t1_rdata", rd, 32'h0000_4141);
        check("t1_rd_latency", lat, 3);

        // 2: wide read in both byte orders
        run_req(1, 0, 1, 4'd2, 32'h0, 1, rd, lat, wec, a2);
        check("t2_big", rd, 32'h0405_0607);
        check("t2_wide_latency", lat, 4);
        run_req(1, 0, 1, 4'd2, 32'h0, 0, rd, lat, wec, a2);
        check("t2_little", rd, 32'h0607_0405);

        // 3: both requesters held valid; grants alternate starting at 0
        req_write = 2'b00; req_wide = 2'b00; req_addr = {4'd3, 4'd2};
        big_endian = 1'b1; req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            got = 0;
            for (int j = 0; j < 20 && !got; j++) begin
                @(negedge clk);
                if (req_ready != 2'b00) got = 1;
            end
            if (!got) begin
                check("t3_grant_timeout", 0, 1);
                break;
            end
            check("t3_onehot", $countones(req_ready), 1);
            g = req_ready[1];
            check("t3_alternate", g, k % 2);
            @(posedge clk); #1;
            req_addr[g*4 +: 4] = req_addr[g*4 +: 4] + 4'd5;
        end
        req_valid = 2'b00;
        repeat (6) @(posedge clk); #1;

        // 4: wide read wrapping from 15 to 0
        run_req(0, 0, 1, 4'd15, 32'h0, 1, rd, lat, wec, a2);
        check("t4_wrap_addr", a2, 4'd0);
        check("t4_rdata", rd, 32'hABCD_1111);

        // 5: wide big-endian write, then read it back little-endian
        run_req(1, 1, 1, 4'd4, 32'h1234_5678, 1, rd, lat, wec, a2);
        check("t5_we_cycles", wec, 2);
        check("t5_mem4", mem[4], 16'h1234);
        check("t5_mem5", mem[5], 16'h5678);
        check("t5_wr_rdata", rd, 32'h0);
        run_req(0, 0, 1, 4'd4, 32'h0, 0, rd, lat, wec, a2);
        check("t5_readback_le", rd, 32'h5678_1234);

        // 6: reset in the middle of a wide write's second access
        req_write[0] = 1'b1; req_wide[0] = 1'b1; req_addr[3:0] = 4'd8;
        req_wdata[31:0] = 32'hCAFE_BABE; big_endian = 1'b1; req_valid[0] = 1'b1;
        got = 0;
        for (int j = 0; j < 20 && !got; j++) begin
            @(negedge clk);
            if (req_ready[0]) got = 1;
        end
        if (!got) check("t6_grant_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #2;
        check("t6_we_in_acc1", ram_we, 1);
        rst = 1'b1;
        #1;
        check("t6_we_at_rst", ram_we, 0);
        check("t6_rsp_at_rst", rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        saw = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid) saw = 1;
        end
        check("t6_no_rsp", saw, 0);
        check("t6_mem8", mem[8], 16'hCAFE);
        check("t6_mem9_untouched", mem[9], 16'h1009);
        @(posedge clk); #1;
        run_req(1, 0, 0, 4'd2, 32'h0, 1, rd, lat, wec, a2);
        check("t6_after_rdata", rd, 32'h0000_0405);
        check("t6_after_latency", lat, 3);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
